// File: rtl/sample_sequencer.sv
// Frame scheduler: latches four samples per sample_clk edge, serves each plugged
// channel through one shared valid/ready core and commits all four results at once.
module sample_sequencer #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic signed [W-1:0] sample_in0,
    input  logic signed [W-1:0] sample_in1,
    input  logic signed [W-1:0] sample_in2,
    input  logic signed [W-1:0] sample_in3,
    input  logic [7:0]          jack,
    output logic signed [W-1:0] sample_out0,
    output logic signed [W-1:0] sample_out1,
    output logic signed [W-1:0] sample_out2,
    output logic signed [W-1:0] sample_out3,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [1:0]          req_ch,
    output logic signed [W-1:0] req_data,
    input  logic                resp_valid,
    input  logic [1:0]          resp_ch,
    input  logic signed [W-1:0] resp_data,
    output logic                busy,
    output logic                overrun,
    output logic                timeout,
    input  logic                clear_flags
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

    state_t              state, state_nx;
    logic                sclk_q;
    logic [1:0]          k;
    logic [CW-1:0]       cnt;
    logic [3:0]          jk;
    logic signed [W-1:0] lat   [4];
    logic signed [W-1:0] res   [4];
    logic signed [W-1:0] out_q [4];
    logic signed [W-1:0] sample_in [4];

    logic                edge_seen, start, last_cycle;
    logic                advance, res_we, tmo_hit;
    logic signed [W-1:0] res_wdata;
    logic                jack_unused;

    assign sample_in[0] = sample_in0;
    assign sample_in[1] = sample_in1;
    assign sample_in[2] = sample_in2;
    assign sample_in[3] = sample_in3;
    assign jack_unused  = ^jack[7:4];

    assign edge_seen  = sample_clk & ~sclk_q;
    assign start      = (state == IDLE) & edge_seen;
    // The last cycle a plugged channel may occupy; it spends exactly TIMEOUT cycles at most.
    assign last_cycle = (cnt == CW'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sclk_q <= 1'b0;
        end else begin
            state  <= state_nx;
            sclk_q <= sample_clk;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx  = state;
        advance   = 1'b0;
        res_we    = 1'b0;
        res_wdata = '0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_seen) state_nx = ISSUE;
            end
            ISSUE: begin
                if (!jk[k]) begin
                    advance = 1'b1;
                    res_we  = 1'b1;
                end else if (last_cycle) begin
                    advance   = 1'b1;
                    res_we    = 1'b1;
                    res_wdata = lat[k];
                    tmo_hit   = 1'b1;
                end else if (req_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid && resp_ch == k) begin
                    advance   = 1'b1;
                    res_we    = 1'b1;
                    res_wdata = resp_data;
                end else if (last_cycle) begin
                    advance   = 1'b1;
                    res_we    = 1'b1;
                    res_wdata = lat[k];
                    tmo_hit   = 1'b1;
                end
            end
            COMMIT: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (advance) state_nx = (k == 2'd3) ? COMMIT : ISSUE;
    end

    // NOTE: the small sample arrays are reset so outputs are defined and an aborted frame leaves no stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k       <= 2'd0;
            cnt     <= '0;
            jk      <= 4'd0;
            overrun <= 1'b0;
            timeout <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lat[i]   <= '0;
                res[i]   <= '0;
                out_q[i] <= '0;
            end
        end else begin
            if (start) begin
                jk <= jack[3:0];
                for (int i = 0; i < 4; i++) lat[i] <= sample_in[i];
            end

            if (start) k <= 2'd0;
            else if (advance) k <= k + 2'd1;

            if (start || advance) cnt <= '0;
            else if (state == ISSUE || state == WAIT) cnt <= cnt + CW'(1);

            if (res_we) res[k] <= res_wdata;

            if (state == COMMIT) begin
                for (int i = 0; i < 4; i++) out_q[i] <= res[i];
            end

            // A set in the same cycle as clear_flags wins.
            if (edge_seen && state != IDLE) overrun <= 1'b1;
            else if (clear_flags)           overrun <= 1'b0;

            if (tmo_hit)          timeout <= 1'b1;
            else if (clear_flags) timeout <= 1'b0;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        req_valid = (state == ISSUE) && jk[k];
        req_ch    = 2'd0;
        req_data  = '0;
        if ((state == ISSUE) && jk[k]) begin
            req_ch   = k;
            req_data = lat[k];
        end
    end

    assign sample_out0 = out_q[0];
    assign sample_out1 = out_q[1];
    assign sample_out2 = out_q[2];
    assign sample_out3 = out_q[3];

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer: one task per scenario, expectations hand-computed
// from the frame timeline (edge accepted at E, ISSUE(0) at E+1).
module tb_sample_sequencer;
    localparam int W  = 16;
    localparam int TO = 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                sample_clk;
    logic signed [W-1:0] sample_in0, sample_in1, sample_in2, sample_in3;
    logic [7:0]          jack;
    logic signed [W-1:0] sample_out0, sample_out1, sample_out2, sample_out3;
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_ch;
    logic signed [W-1:0] req_data;
    logic                resp_valid;
    logic [1:0]          resp_ch;
    logic signed [W-1:0] resp_data;
    logic                busy, overrun, timeout;
    logic                clear_flags;

    int n_cmp = 0;
    int n_bad = 0;

    logic [4*W-1:0] outs;
    assign outs = {sample_out0, sample_out1, sample_out2, sample_out3};

    sample_sequencer #(.W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk),
        .sample_in0(sample_in0), .sample_in1(sample_in1),
        .sample_in2(sample_in2), .sample_in3(sample_in3),
        .jack(jack),
        .sample_out0(sample_out0), .sample_out1(sample_out1),
        .sample_out2(sample_out2), .sample_out3(sample_out3),
        .req_valid(req_valid), .req_ready(req_ready), .req_ch(req_ch), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ch(resp_ch), .resp_data(resp_data),
        .busy(busy), .overrun(overrun), .timeout(timeout), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [4*W-1:0] pack4(input logic signed [W-1:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    task automatic set_samples(input logic signed [W-1:0] a, b, c, d);
        sample_in0 = a; sample_in1 = b; sample_in2 = c; sample_in3 = d;
    endtask

    // Raises sample_clk at a falling edge; the following rising edge is cycle E.
    task automatic raise_frame_edge();
        @(negedge clk);
        sample_clk = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sample_clk = 1'b0; jack = 8'h00; req_ready = 1'b0;
        resp_valid = 1'b0; resp_ch = 2'd0; resp_data = '0; clear_flags = 1'b0;
        set_samples(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs !== '0) begin
            n_bad++; $display("FAIL reset_outs: got %h want 0", outs);
        end
        n_cmp++;
        if ({req_valid, req_ch, req_data, busy, overrun, timeout} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got valid=%b ch=%0d data=%0d busy=%b ovr=%b tmo=%b want all 0",
                     req_valid, req_ch, req_data, busy, overrun, timeout);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_all_plugged();
        logic signed [W-1:0] held, exp_d;
        logic [1:0]          exp_ch;
        held = '0;
        set_samples(16'sd10, 16'sd20, 16'sd30, 16'sd40);
        jack = 8'h0F; req_ready = 1'b1;
        raise_frame_edge();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            resp_valid = 1'b0;
            if (i <= 8 && (i % 2) == 1) begin
                exp_ch = 2'((i - 1) / 2);
                exp_d  = W'(10 * ((i + 1) / 2));
                n_cmp++;
                if ({req_valid, req_ch, req_data} !== {1'b1, exp_ch, exp_d}) begin
                    n_bad++;
                    $display("FAIL plugged_req i=%0d: got valid=%b ch=%0d data=%0d want 1/%0d/%0d",
                             i, req_valid, req_ch, req_data, exp_ch, exp_d);
                end
                held = req_data;
            end else if (i <= 8) begin
                n_cmp++;
                if (req_valid !== 1'b0) begin
                    n_bad++; $display("FAIL plugged_one_outstanding i=%0d: got valid=%b want 0", i, req_valid);
                end
                resp_valid = 1'b1; resp_ch = 2'((i - 2) / 2); resp_data = held + 16'sd1;
            end
            if (i == 9) begin
                n_cmp++;
                if ({busy, outs} !== {1'b1, pack4(0, 0, 0, 0)}) begin
                    n_bad++; $display("FAIL plugged_commit_cycle: got busy=%b outs=%h want busy=1 outs=0", busy, outs);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if ({busy, outs} !== {1'b0, pack4(11, 21, 31, 41)}) begin
                    n_bad++;
                    $display("FAIL plugged_outputs: got busy=%b outs=%h want busy=0 outs=%h",
                             busy, outs, pack4(11, 21, 31, 41));
                end
            end
        end
        resp_valid = 1'b0;
    endtask

    task automatic test_all_unplugged();
        set_samples(16'sd100, 16'sd200, 16'sd300, 16'sd400);
        jack = 8'h00; req_ready = 1'b0;
        raise_frame_edge();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            if (i <= 5) begin
                n_cmp++;
                if ({busy, req_valid} !== 2'b10) begin
                    n_bad++; $display("FAIL unplugged_busy i=%0d: got busy=%b valid=%b want 1/0", i, busy, req_valid);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (outs !== pack4(11, 21, 31, 41)) begin
                    n_bad++; $display("FAIL unplugged_hold i=5: got %h want %h", outs, pack4(11, 21, 31, 41));
                end
            end
            if (i == 6) begin
                n_cmp++;
                if ({busy, outs} !== {1'b0, pack4(0, 0, 0, 0)}) begin
                    n_bad++; $display("FAIL unplugged_outputs: got busy=%b outs=%h want 0/0", busy, outs);
                end
            end
        end
    endtask

    task automatic test_ready_stall();
        // Upper jack bits are don't-care.
        set_samples(16'sd7, 16'sd55, 16'sd66, 16'sd77);
        jack = 8'hF1; req_ready = 1'b0;
        raise_frame_edge();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            resp_valid = 1'b0;
            if (i <= 3) begin
                n_cmp++;
                if ({req_valid, req_ch, req_data} !== {1'b1, 2'd0, 16'sd7}) begin
                    n_bad++;
                    $display("FAIL stall_stable i=%0d: got valid=%b ch=%0d data=%0d want 1/0/7",
                             i, req_valid, req_ch, req_data);
                end
            end
            if (i == 2) begin
                sample_in0 = 16'sd999; jack = 8'h00;
            end
            if (i == 3) req_ready = 1'b1;
            if (i == 4) begin
                n_cmp++;
                if ({busy, req_valid} !== 2'b10) begin
                    n_bad++; $display("FAIL stall_wait: got busy=%b valid=%b want 1/0", busy, req_valid);
                end
                resp_valid = 1'b1; resp_ch = 2'd0; resp_data = 16'sd1234;
            end
            if (i == 8) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++; $display("FAIL stall_commit_busy: got %b want 1", busy);
                end
            end
            if (i == 9) begin
                n_cmp++;
                if ({busy, outs} !== {1'b0, pack4(1234, 0, 0, 0)}) begin
                    n_bad++;
                    $display("FAIL stall_outputs: got busy=%b outs=%h want 0/%h", busy, outs, pack4(1234, 0, 0, 0));
                end
            end
        end
    endtask

    task automatic test_timeout();
        set_samples(16'sd1, 16'sd2, -16'sd5, 16'sd3);
        jack = 8'h04; req_ready = 1'b0;
        raise_frame_edge();
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            if (i <= 2 || i == 11) begin
                n_cmp++;
                if (req_valid !== 1'b0) begin
                    n_bad++; $display("FAIL timeout_idle_req i=%0d: got valid=%b want 0", i, req_valid);
                end
            end
            if (i >= 3 && i <= 10) begin
                n_cmp++;
                if ({req_valid, req_ch, req_data} !== {1'b1, 2'd2, -16'sd5}) begin
                    n_bad++;
                    $display("FAIL timeout_req i=%0d: got valid=%b ch=%0d data=%0d want 1/2/-5",
                             i, req_valid, req_ch, req_data);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_bad++; $display("FAIL timeout_early: got %b want 0", timeout);
                end
            end
            if (i == 11) begin
                n_cmp++;
                if ({busy, timeout} !== 2'b11) begin
                    n_bad++; $display("FAIL timeout_flag: got busy=%b tmo=%b want 1/1", busy, timeout);
                end
            end
            if (i == 12) begin
                n_cmp++;
                if (outs !== pack4(1234, 0, 0, 0)) begin
                    n_bad++; $display("FAIL timeout_hold: got %h want %h", outs, pack4(1234, 0, 0, 0));
                end
            end
            if (i == 13) begin
                n_cmp++;
                if ({busy, timeout, outs} !== {2'b01, pack4(0, 0, -5, 0)}) begin
                    n_bad++;
                    $display("FAIL timeout_outputs: got busy=%b tmo=%b outs=%h want 0/1/%h",
                             busy, timeout, outs, pack4(0, 0, -5, 0));
                end
                clear_flags = 1'b1;
            end
            if (i == 14) begin
                clear_flags = 1'b0;
                n_cmp++;
                if (timeout !== 1'b0) begin
                    n_bad++; $display("FAIL timeout_clear: got %b want 0", timeout);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic signed [W-1:0] held, exp_d;
        held = '0;
        set_samples(16'sd1, 16'sd2, 16'sd3, 16'sd4);
        jack = 8'h0F; req_ready = 1'b1;
        raise_frame_edge();
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            resp_valid = 1'b0;
            if (i <= 8 && (i % 2) == 1) begin
                exp_d = W'((i + 1) / 2);
                n_cmp++;
                if ({req_valid, req_data} !== {1'b1, exp_d}) begin
                    n_bad++;
                    $display("FAIL overrun_req i=%0d: got valid=%b data=%0d want 1/%0d", i, req_valid, req_data, exp_d);
                end
                held = req_data;
            end else if (i <= 8) begin
                resp_valid = 1'b1; resp_ch = 2'((i - 2) / 2); resp_data = held + 16'sd1;
            end
            if (i == 2) begin
                n_cmp++;
                if (overrun !== 1'b0) begin
                    n_bad++; $display("FAIL overrun_early: got %b want 0", overrun);
                end
                sample_clk = 1'b1;
                set_samples(16'sd90, 16'sd91, 16'sd92, 16'sd93);
                jack = 8'h00;
            end
            if (i == 3) begin
                sample_clk = 1'b0;
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_bad++; $display("FAIL overrun_flag: got %b want 1", overrun);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if ({busy, overrun, outs} !== {2'b01, pack4(2, 3, 4, 5)}) begin
                    n_bad++;
                    $display("FAIL overrun_outputs: got busy=%b ovr=%b outs=%h want 0/1/%h",
                             busy, overrun, outs, pack4(2, 3, 4, 5));
                end
                clear_flags = 1'b1;
            end
        end
        @(negedge clk);
        clear_flags = 1'b0;
        n_cmp++;
        if ({busy, overrun} !== 2'b00) begin
            n_bad++; $display("FAIL overrun_clear: got busy=%b ovr=%b want 0/0", busy, overrun);
        end
        sample_clk = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) begin
                sample_clk = 1'b0;
                n_cmp++;
                if ({busy, overrun} !== 2'b10) begin
                    n_bad++; $display("FAIL overrun_next_edge: got busy=%b ovr=%b want 1/0", busy, overrun);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if ({busy, outs} !== {1'b0, pack4(0, 0, 0, 0)}) begin
                    n_bad++; $display("FAIL overrun_next_frame: got busy=%b outs=%h want 0/0", busy, outs);
                end
            end
        end
    endtask

    task automatic test_wrong_tag();
        set_samples(16'sd0, 16'sd50, 16'sd0, 16'sd0);
        jack = 8'h02; req_ready = 1'b1;
        raise_frame_edge();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) sample_clk = 1'b0;
            resp_valid = 1'b0;
            if (i == 2) begin
                n_cmp++;
                if ({req_valid, req_ch, req_data} !== {1'b1, 2'd1, 16'sd50}) begin
                    n_bad++;
                    $display("FAIL tag_req: got valid=%b ch=%0d data=%0d want 1/1/50", req_valid, req_ch, req_data);
                end
            end
            if (i == 3) begin
                resp_valid = 1'b1; resp_ch = 2'd3; resp_data = 16'sd777;
            end
            if (i == 4) begin
                n_cmp++;
                if ({busy, req_valid} !== 2'b10) begin
                    n_bad++; $display("FAIL tag_still_waiting: got busy=%b valid=%b want 1/0", busy, req_valid);
                end
                resp_valid = 1'b1; resp_ch = 2'd1; resp_data = 16'sd555;
            end
            if (i == 7) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_bad++; $display("FAIL tag_commit_busy: got %b want 1", busy);
                end
            end
            if (i == 8) begin
                n_cmp++;
                if ({busy, outs} !== {1'b0, pack4(0, 555, 0, 0)}) begin
                    n_bad++; $display("FAIL tag_outputs: got busy=%b outs=%h want 0/%h", busy, outs, pack4(0, 555, 0, 0));
                end
            end
        end
        resp_valid = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        set_samples(16'sd9, 16'sd0, 16'sd0, 16'sd0);
        jack = 8'h01; req_ready = 1'b1;
        raise_frame_edge();
        @(negedge clk);
        sample_clk = 1'b0;
        n_cmp++;
        if (req_valid !== 1'b1) begin
            n_bad++; $display("FAIL rst_pre_req: got %b want 1", req_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, req_valid} !== 2'b10) begin
            n_bad++; $display("FAIL rst_pre_wait: got busy=%b valid=%b want 1/0", busy, req_valid);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, req_valid, outs} !== '0) begin
            n_bad++; $display("FAIL rst_async: got busy=%b valid=%b outs=%h want all 0", busy, req_valid, outs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, outs} !== '0) begin
            n_bad++; $display("FAIL rst_after: got busy=%b outs=%h want 0/0", busy, outs);
        end
    endtask

    initial begin
        test_reset();
        test_all_plugged();
        test_all_unplugged();
        test_ready_stall();
        test_timeout();
        test_overrun();
        test_wrong_tag();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
